// File: rtl/socket_frame_reader.sv
// Pops samples from a socket FIFO (one-cycle read latency) and packs FRAME_SIZE of them
// into one frame word, handed downstream with a valid/ready handshake.
module socket_frame_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_SIZE = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             empty,
  output logic                             rd_en,
  input  logic                             fifo_dv,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic [DATA_WIDTH*FRAME_SIZE-1:0] frame_data,
  output logic                             frame_dv,
  input  logic                             frame_rdy,
  output logic [CNT_WIDTH-1:0]             frame_cnt,
  output logic                             overrun_err
);

  localparam int IW = $clog2(FRAME_SIZE + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [IW-1:0]        issued_cnt_reg, issued_cnt_next;
  logic [IW-1:0]        recv_cnt_reg, recv_cnt_next;
  logic                 frame_dv_reg, frame_dv_next;
  logic [CNT_WIDTH-1:0] frame_cnt_reg, frame_cnt_next;
  logic                 overrun_reg, overrun_next;
  logic                 capture;
  logic                 spurious;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FILL;
      issued_cnt_reg <= '0;
      recv_cnt_reg   <= '0;
      frame_dv_reg   <= 1'b0;
      frame_cnt_reg  <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      issued_cnt_reg <= issued_cnt_next;
      recv_cnt_reg   <= recv_cnt_next;
      frame_dv_reg   <= frame_dv_next;
      frame_cnt_reg  <= frame_cnt_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    issued_cnt_next = issued_cnt_reg;
    recv_cnt_next   = recv_cnt_reg;
    frame_dv_next   = frame_dv_reg;
    frame_cnt_next  = frame_cnt_reg;
    overrun_next    = overrun_reg;
    rd_en           = 1'b0;
    capture         = 1'b0;
    spurious        = 1'b0;
    case (state_reg)
      FILL: begin
        rd_en = !rst && !empty && (issued_cnt_reg < IW'(FRAME_SIZE));
        if (rd_en) issued_cnt_next = issued_cnt_reg + IW'(1);
        // With no read outstanding, returned data cannot belong to this frame.
        if (fifo_dv) begin
          if (issued_cnt_reg == recv_cnt_reg) begin
            spurious = 1'b1;
          end else begin
            capture       = 1'b1;
            recv_cnt_next = recv_cnt_reg + IW'(1);
            if (recv_cnt_reg == IW'(FRAME_SIZE - 1)) begin
              state_next    = HOLD;
              frame_dv_next = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        spurious = fifo_dv;
        if (frame_rdy) begin
          frame_dv_next   = 1'b0;
          frame_cnt_next  = frame_cnt_reg + CNT_WIDTH'(1);
          issued_cnt_next = '0;
          recv_cnt_next   = '0;
          state_next      = FILL;
        end
      end
      default: state_next = FILL;
    endcase
    if (spurious) overrun_next = 1'b1;
  end

  // One register per lane; unwritten lanes keep their previous-frame contents.
  for (genvar gi = 0; gi < FRAME_SIZE; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= '0;
      end else if (capture && (recv_cnt_reg == IW'(gi))) begin
        lane_reg <= fifo_data;
      end
    end
    assign frame_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
  end

  assign frame_dv    = frame_dv_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign overrun_err = overrun_reg;

endmodule

// File: tb/tb_socket_frame_reader.sv
// Scoreboard bench: a FIFO model feeds the reader, expected frames are formed from the
// pushed sample stream in groups of four, and a monitor checks every accepted frame.
module tb_socket_frame_reader;
  localparam int DW = 8;
  localparam int FS = 4;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             empty;
  logic             rd_en;
  logic             fifo_dv;
  logic [DW-1:0]    fifo_data;
  logic [DW*FS-1:0] frame_data;
  logic             frame_dv;
  logic             frame_rdy = 1'b0;
  logic [CW-1:0]    frame_cnt;
  logic             overrun_err;

  socket_frame_reader #(.DATA_WIDTH(DW), .FRAME_SIZE(FS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .empty(empty), .rd_en(rd_en), .fifo_dv(fifo_dv),
    .fifo_data(fifo_data), .frame_data(frame_data), .frame_dv(frame_dv),
    .frame_rdy(frame_rdy), .frame_cnt(frame_cnt), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  logic        starve = 1'b0;
  logic        inject_req = 1'b0;
  int          rd_count = 0;
  int          rd_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the sample stream since reset, cut into groups of FS, lane 0 first.
  task automatic push_sample(input logic [7:0] s);
    logic [31:0] f;
    fifo_q.push_back(s);
    part_q.push_back(s);
    if (part_q.size() == FS) begin
      f = '0;
      for (int k = 0; k < FS; k++) f[k*DW +: DW] = part_q[k];
      exp_q.push_back(f);
      part_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    fifo_q.delete();
    part_q.delete();
    exp_q.delete();
    starve = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rd_en_in_reset", rd_en, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_exp_empty(input int n, input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < n) begin
      @(negedge clk);
      i++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_dv(input int n, input string name);
    int i = 0;
    while (!frame_dv && i < n) begin
      @(negedge clk);
      i++;
    end
    check(name, frame_dv, 1);
  endtask

  // FIFO model: data returns one cycle after an accepted read.
  initial begin
    logic take;
    fifo_dv = 1'b0;
    fifo_data = '0;
    empty = 1'b1;
    forever begin
      @(negedge clk);
      take = rd_en;
      if (take) begin
        rd_count++;
        check("rd_en_while_empty", empty, 0);
      end
      @(posedge clk);
      #1;
      if (take && fifo_q.size() > 0) begin
        fifo_dv = 1'b1;
        fifo_data = fifo_q.pop_front();
      end else if (inject_req) begin
        fifo_dv = 1'b1;
        fifo_data = 8'hAA;
      end else begin
        fifo_dv = 1'b0;
        fifo_data = 8'($urandom);
      end
      #1 empty = (fifo_q.size() == 0) || starve;
    end
  end

  // Monitor: compares each accepted frame and checks stability under backpressure.
  initial begin
    int          acc;
    logic        prev_dv;
    logic        prev_acc;
    logic [31:0] prev_data;
    logic [31:0] exp;
    acc = 0;
    prev_dv = 1'b0;
    prev_acc = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = 0;
        prev_dv = 1'b0;
      end else begin
        if (prev_dv && !prev_acc && frame_dv) check("frame_stable", frame_data, prev_data);
        if (frame_dv && frame_rdy) begin
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("frame_data", frame_data, exp);
            check("frame_cnt_at_accept", 32'(frame_cnt), 32'(acc % 65536));
          end
          $display("frame %0d accepted data=0x%08h", acc, frame_data);
          acc++;
        end
        prev_dv = frame_dv;
        prev_acc = frame_dv && frame_rdy;
        prev_data = frame_data;
      end
    end
  end

  initial begin
    // Reset with a non-empty FIFO, then a single frame.
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) push_sample(8'(8'h11 * i));
    repeat (2) begin
      @(negedge clk);
      check("rd_en_in_reset", rd_en, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    frame_rdy = 1'b1;
    rd_base = rd_count;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("reset_frame_dv", frame_dv, 0);
        check("reset_frame_data", frame_data, 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        check("reset_overrun", overrun_err, 0);
      end
      check("single_rd_en", rd_en, cyc < 4);
      check("single_frame_dv", frame_dv, cyc == 5);
    end
    check("single_frame_cnt", 32'(frame_cnt), 1);
    check("single_rd_pulses", rd_count - rd_base, 4);
    check("single_exp_left", exp_q.size(), 0);

    // Backpressure.
    frame_rdy = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) push_sample(8'(8'h11 * i));
    rd_base = rd_count;
    repeat (16) @(negedge clk);
    check("bp_frame_dv", frame_dv, 1);
    check("bp_frame_data", frame_data, 32'h44332211);
    check("bp_rd_pulses", rd_count - rd_base, 4);
    check("bp_frame_cnt", 32'(frame_cnt), 0);
    tick();
    frame_rdy = 1'b1;
    wait_exp_empty(60, "bp_timeout");
    check("bp_frame_cnt_end", 32'(frame_cnt), 2);

    // Starved FIFO: one sample every three cycles.
    do_reset();
    rd_base = rd_count;
    for (int i = 1; i <= 4; i++) begin
      push_sample(8'(8'h11 * i));
      repeat (3) tick();
    end
    wait_exp_empty(40, "starve_timeout");
    check("starve_rd_pulses", rd_count - rd_base, 4);

    // Spurious dv while holding a frame.
    frame_rdy = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) push_sample(8'(8'h11 * i));
    wait_dv(30, "spur_dv_timeout");
    @(negedge clk);
    inject_req = 1'b1;
    @(negedge clk);
    inject_req = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_overrun", overrun_err, 1);
    check("spur_frame_data", frame_data, 32'h44332211);
    check("spur_frame_dv", frame_dv, 1);
    tick();
    frame_rdy = 1'b1;
    wait_exp_empty(20, "spur_timeout");
    check("spur_overrun_sticky", overrun_err, 1);
    do_reset();
    @(negedge clk);
    check("spur_overrun_cleared", overrun_err, 0);

    // Reset mid-frame.
    push_sample(8'h11);
    push_sample(8'h22);
    repeat (6) @(negedge clk);
    do_reset();
    @(negedge clk);
    check("mid_frame_cnt", 32'(frame_cnt), 0);
    check("mid_frame_data", frame_data, 0);
    tick();
    for (int i = 5; i <= 8; i++) push_sample(8'(8'h11 * i));
    wait_exp_empty(30, "mid_timeout");
    check("mid_frame_cnt_end", 32'(frame_cnt), 1);

    // Randomised traffic with starvation and backpressure.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      frame_rdy = ($urandom % 3) != 0;
      starve = ($urandom % 4) == 0;
      if ($urandom % 2 == 1) push_sample(8'($urandom));
    end
    tick();
    starve = 1'b0;
    frame_rdy = 1'b1;
    wait_exp_empty(400, "rand_timeout");
    check("rand_overrun", overrun_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/socket_frame_reader.md
Name: socket_frame_reader

Overview:
- Consumer-side end of the socket FIFO interface: pops samples from a FIFO via rd_en/empty, captures the one-cycle-late dv/data return, and packs FRAME_SIZE consecutive samples into one frame word.
- Presents each complete frame to the downstream processing module through a valid/ready handshake.
- Sits between a socket FIFO's read port and a module's frame-parallel input.

Parameters:
- DATA_WIDTH, 8, width of one FIFO sample.
- FRAME_SIZE, 4, samples per frame (>=2).
- CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- empty  in  1  FIFO empty flag.
- rd_en  out  1  read request to FIFO, one sample per asserted cycle.
- fifo_dv  in  1  FIFO read-data valid, one cycle after an accepted rd_en.
- fifo_data  in  DATA_WIDTH  FIFO read data, qualified by fifo_dv.
- frame_data  out  DATA_WIDTH*FRAME_SIZE  assembled frame; sample k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- frame_dv  out  1  frame valid.
- frame_rdy  in  1  downstream accepts the frame when frame_dv && frame_rdy.
- frame_cnt  out  CNT_WIDTH  number of frames accepted downstream since reset.
- overrun_err  out  1  sticky: fifo_dv seen with no read outstanding.

Behaviour:
- Reset (rst=1 at a rising edge), next-cycle values:
  - Outputs: frame_dv=0, frame_data=0, frame_cnt=0, overrun_err=0.
  - Internal: issued_cnt=0, recv_cnt=0, state=FILL.
  - rd_en is held 0 combinationally while rst=1.
- Reset mid-frame drops the partial frame. The first sample after reset goes to lane 0.
- A fifo_dv arriving in the cycle right after reset release, from a read issued before reset, is treated as spurious: overrun_err=1.
- FSM, two states:
  - FILL: rd_en = !rst && !empty && (issued_cnt < FRAME_SIZE), combinational. Each rd_en cycle increments issued_cnt.
  - FILL capture: each fifo_dv cycle writes fifo_data into lane recv_cnt of the frame register and increments recv_cnt.
  - FILL exit: when the capture makes recv_cnt reach FRAME_SIZE, go to HOLD and set frame_dv=1 on the same edge.
  - HOLD: rd_en=0; frame_data is frozen.
  - HOLD exit: on an edge with frame_rdy=1, clear frame_dv, increment frame_cnt (wraps modulo 2^CNT_WIDTH), clear issued_cnt and recv_cnt, and go to FILL.
- Read latency accounting:
  - The FIFO returns data exactly one cycle after rd_en, so outstanding reads (issued_cnt - recv_cnt) are 0 or 1.
  - Reads may be issued on consecutive cycles while empty=0. There are never more than FRAME_SIZE reads per frame.
- Timing with a continuously non-empty FIFO and frame_rdy=1:
  - rd_en in cycles 0..N-1.
  - frame_dv=1 in cycle N+1.
  - Accepted at the end of cycle N+1.
  - rd_en again in cycle N+2.
  - Frame period is FRAME_SIZE+2 cycles.
- Starvation: when empty=1 in FILL, rd_en=0 and state is held. Partial lanes keep their values. No timeout.
- Backpressure: frame_dv stays 1 and frame_data stays stable for as long as frame_rdy=0. No FIFO reads happen while in HOLD.
- Spurious data: a fifo_dv with issued_cnt==recv_cnt, or any fifo_dv in HOLD, sets overrun_err=1.
  - The sample is discarded; frame_data and the counters are unaffected.
  - overrun_err clears only on rst.
- frame_rdy while frame_dv=0 is ignored.
- Lanes not yet written in the current frame keep their previous-frame contents (0 after reset).

Test Plan:
- (DATA_WIDTH=8, FRAME_SIZE=4.)
- Reset: rst=1 for 2 cycles with empty=0 -> rd_en=0 during reset; then frame_dv=0, frame_data=0x00000000, frame_cnt=0, overrun_err=0.
- Single frame: FIFO model preloaded with 0x11,0x22,0x33,0x44, frame_rdy=1 -> rd_en high 4 consecutive cycles (0..3); frame_dv=1 in cycle 5 only; frame_data=0x44332211; frame_cnt=1 afterwards; exactly 4 rd_en pulses.
- Backpressure: 8 samples 0x11..0x88 preloaded, frame_rdy=0 for 10 cycles -> frame_dv=1 and frame_data=0x44332211 stable, no rd_en after the 4th. Then frame_rdy=1 -> second frame 0x88776655, frame_cnt=2.
- Starved FIFO: one sample made available every 3 cycles (empty toggling) -> rd_en only when empty=0; frame assembled in order 0x44332211; 4 rd_en pulses total.
- Spurious dv: fifo_dv=1, fifo_data=0xAA injected while in HOLD -> overrun_err=1 and stays 1; frame_data unchanged. rst -> overrun_err=0.
- Reset mid-frame: rst pulsed after 2 samples (0x11,0x22) received -> frame_cnt=0; next samples 0x55,0x66,0x77,0x88 produce frame_data=0x88776655.
